// File: rtl/pong_motion_ctrl_if.sv
// Signal bundle between the VGA-timed game inputs and the pong motion stage.
// The master side drives pixel counters, buttons and serve; the slave side returns object state.
interface pong_motion_ctrl_if;
   logic [9:0] pixel_x;
   logic [9:0] pixel_y;
   logic       btn_up;
   logic       btn_down;
   logic       serve;
   logic [9:0] bar_y_t;
   logic [9:0] ball_x_l;
   logic [9:0] ball_y_t;
   logic       ball_en;
   logic       hit;
   logic       miss;
   logic [1:0] state;

   modport master (
      output pixel_x, pixel_y, btn_up, btn_down, serve,
      input  bar_y_t, ball_x_l, ball_y_t, ball_en, hit, miss, state
   );

   modport slave (
      input  pixel_x, pixel_y, btn_up, btn_down, serve,
      output bar_y_t, ball_x_l, ball_y_t, ball_en, hit, miss, state
   );
endinterface

// File: rtl/pong_motion_ctrl.sv
// Pong game-state stage: once per video frame moves the paddle and ball,
// resolves wall/paddle/miss events and holds registered object coordinates.
module pong_motion_ctrl #(
   parameter int SCREEN_W  = 640,
   parameter int SCREEN_H  = 480,
   parameter int WALL_X_R  = 35,
   parameter int BAR_X_L   = 600,
   parameter int BAR_H     = 72,
   parameter int BAR_V     = 4,
   parameter int BALL_SIZE = 8,
   parameter int BALL_V    = 2,
   parameter int MISS_HOLD = 60
) (
   input logic               clk,
   input logic               rst,
   pong_motion_ctrl_if.slave bus
);

   localparam int CNT_W = $clog2(MISS_HOLD + 1);

   localparam logic [9:0] BAR_INIT  = 10'((SCREEN_H - BAR_H) / 2);
   localparam logic [9:0] BAR_MAX   = 10'(SCREEN_H - BAR_H);
   localparam logic [9:0] BAR_STEP  = 10'(BAR_V);
   localparam logic [9:0] BALL_X0   = 10'((SCREEN_W - BALL_SIZE) / 2);
   localparam logic [9:0] BALL_Y0   = 10'((SCREEN_H - BALL_SIZE) / 2);
   localparam logic [9:0] BALL_Y_HI = 10'(SCREEN_H - BALL_SIZE);
   localparam logic [9:0] WALL_X    = 10'(WALL_X_R + 1);
   localparam logic [9:0] HIT_X     = 10'(BAR_X_L - BALL_SIZE);
   localparam logic [9:0] TICK_Y    = 10'(SCREEN_H + 1);

   localparam logic signed [11:0] S_V      = 12'(BALL_V);
   localparam logic signed [11:0] S_SZM1   = 12'(BALL_SIZE - 1);
   localparam logic signed [11:0] S_BARX   = 12'(BAR_X_L);
   localparam logic signed [11:0] S_BARHM1 = 12'(BAR_H - 1);
   localparam logic signed [11:0] S_WALL   = 12'(WALL_X_R + 1);
   localparam logic signed [11:0] S_X_MAX  = 12'(SCREEN_W - BALL_SIZE);
   localparam logic signed [11:0] S_Y_MAX  = 12'(SCREEN_H - BALL_SIZE);

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      PLAY = 2'd1,
      MISS = 2'd2
   } state_t;

   state_t             state_q;
   logic [9:0]         bar_q;
   logic [9:0]         bx_q;
   logic [9:0]         by_q;
   logic               vx_neg;
   logic               vy_neg;
   logic               ball_en_q;
   logic               hit_q;
   logic               miss_q;
   logic [CNT_W-1:0]   cnt_q;
   logic               tick_q;

   logic               tick_now;
   logic               frame_tick;
   logic [9:0]         bar_next;
   logic signed [11:0] bx_s;
   logic signed [11:0] bar_s;
   logic signed [11:0] xn;
   logic signed [11:0] yn;
   logic               hit_cond;

   assign tick_now   = (bus.pixel_y == TICK_Y) && (bus.pixel_x == '0);
   assign frame_tick = tick_now && !tick_q;

   always_comb begin
      bar_next = bar_q;
      if (bus.btn_up && !bus.btn_down) begin
         bar_next = (bar_q < BAR_STEP) ? '0 : bar_q - BAR_STEP;
      end else if (bus.btn_down && !bus.btn_up) begin
         bar_next = (bar_q >= BAR_MAX - BAR_STEP) ? BAR_MAX : bar_q + BAR_STEP;
      end
   end

   // Collision tests use the paddle position from before this frame's button update.
   always_comb begin
      bx_s     = $signed({2'b00, bx_q});
      bar_s    = $signed({2'b00, bar_q});
      xn       = bx_s + (vx_neg ? -S_V : S_V);
      yn       = $signed({2'b00, by_q}) + (vy_neg ? -S_V : S_V);
      hit_cond = !vx_neg
               && (bx_s + S_SZM1 < S_BARX)
               && (xn + S_SZM1 >= S_BARX)
               && (yn + S_SZM1 >= bar_s)
               && (yn <= bar_s + S_BARHM1);
   end

   always_ff @(posedge clk) begin
      if (!rst) begin
         state_q   <= IDLE;
         bar_q     <= BAR_INIT;
         bx_q      <= BALL_X0;
         by_q      <= BALL_Y0;
         vx_neg    <= 1'b0;
         vy_neg    <= 1'b0;
         ball_en_q <= 1'b0;
         hit_q     <= 1'b0;
         miss_q    <= 1'b0;
         cnt_q     <= '0;
         tick_q    <= 1'b0;
      end else begin
         tick_q <= tick_now;
         hit_q  <= 1'b0;
         miss_q <= 1'b0;
         if (frame_tick) begin
            bar_q <= bar_next;
         end
         case (state_q)
            IDLE: begin
               if (frame_tick && bus.serve) begin
                  state_q   <= PLAY;
                  vx_neg    <= 1'b0;
                  vy_neg    <= 1'b0;
                  ball_en_q <= 1'b1;
               end
            end
            PLAY: begin
               if (frame_tick) begin
                  if (yn <= 12'sd0) begin
                     by_q   <= '0;
                     vy_neg <= 1'b0;
                  end else if (yn >= S_Y_MAX) begin
                     by_q   <= BALL_Y_HI;
                     vy_neg <= 1'b1;
                  end else begin
                     by_q <= yn[9:0];
                  end
                  // X events are prioritised so hit and miss can never fire together.
                  if (xn <= S_WALL) begin
                     bx_q   <= WALL_X;
                     vx_neg <= 1'b0;
                  end else if (hit_cond) begin
                     bx_q   <= HIT_X;
                     vx_neg <= 1'b1;
                     hit_q  <= 1'b1;
                  end else if (xn > S_X_MAX) begin
                     state_q   <= MISS;
                     miss_q    <= 1'b1;
                     ball_en_q <= 1'b0;
                     cnt_q     <= CNT_W'(MISS_HOLD - 1);
                  end else begin
                     bx_q <= xn[9:0];
                  end
               end
            end
            MISS: begin
               if (frame_tick) begin
                  if (cnt_q == '0) begin
                     state_q <= IDLE;
                     bx_q    <= BALL_X0;
                     by_q    <= BALL_Y0;
                     vx_neg  <= 1'b0;
                     vy_neg  <= 1'b0;
                  end else begin
                     cnt_q <= cnt_q - 1'b1;
                  end
               end
            end
            default: begin
               state_q   <= IDLE;
               ball_en_q <= 1'b0;
            end
         endcase
      end
   end

   assign bus.bar_y_t  = bar_q;
   assign bus.ball_x_l = bx_q;
   assign bus.ball_y_t = by_q;
   assign bus.ball_en  = ball_en_q;
   assign bus.hit      = hit_q;
   assign bus.miss     = miss_q;
   assign bus.state    = state_q;

endmodule

// File: tb/tb_pong_motion_ctrl.sv
// Directed bench for pong_motion_ctrl: reset, paddle clamp, wall bounce, paddle hit,
// miss hold-off and reset during play, with hand-computed expectations.
module tb_pong_motion_ctrl;

   logic clk = 1'b0;
   logic rst = 1'b0;
   int   checks = 0;
   int   passed = 0;
   int   fails  = 0;
   int   hit_n  = 0;
   int   miss_n = 0;
   int   hit_tot  = 0;
   int   miss_tot = 0;

   pong_motion_ctrl_if bus ();

   pong_motion_ctrl #(
      .SCREEN_W  (640),
      .SCREEN_H  (480),
      .MISS_HOLD (60)
   ) dut (
      .clk (clk),
      .rst (rst),
      .bus (bus)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input int obs, input int exp);
      checks++;
      assert (obs === exp) passed++;
      else begin
         fails++;
         $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
      end
   endtask

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b0;
      bus.pixel_x = '0;
      bus.pixel_y = '0;
      repeat (2) @(negedge clk);
      rst = 1'b1;
      hit_tot  = 0;
      miss_tot = 0;
   endtask

   // One frame: the tick coordinate pair is held for 4 clks; hit/miss are sampled every clk.
   task automatic frame(input logic up, input logic dn, input logic srv);
      @(negedge clk);
      bus.btn_up   = up;
      bus.btn_down = dn;
      bus.serve    = srv;
      bus.pixel_y  = 10'd481;
      bus.pixel_x  = 10'd0;
      hit_n  = 0;
      miss_n = 0;
      repeat (4) begin
         @(negedge clk);
         hit_n  += int'(bus.hit);
         miss_n += int'(bus.miss);
      end
      bus.pixel_y = 10'd0;
      @(negedge clk);
      hit_n  += int'(bus.hit);
      miss_n += int'(bus.miss);
      hit_tot  += hit_n;
      miss_tot += miss_n;
   endtask

   initial begin
      bus.pixel_x  = '0;
      bus.pixel_y  = '0;
      bus.btn_up   = 1'b0;
      bus.btn_down = 1'b0;
      bus.serve    = 1'b0;

      // reset values
      repeat (2) @(negedge clk);
      check("rst_bar", bus.bar_y_t, 204);
      check("rst_bx", bus.ball_x_l, 316);
      check("rst_by", bus.ball_y_t, 236);
      check("rst_en", bus.ball_en, 0);
      check("rst_state", bus.state, 0);
      check("rst_hit", bus.hit, 0);
      check("rst_miss", bus.miss, 0);
      rst = 1'b1;

      // paddle: one update per held tick, clamp at 0, both buttons hold
      frame(1'b1, 1'b0, 1'b0);
      check("bar_one_tick", bus.bar_y_t, 200);
      repeat (4) frame(1'b1, 1'b0, 1'b0);
      check("bar_up5", bus.bar_y_t, 184);
      repeat (60) frame(1'b1, 1'b0, 1'b0);
      check("bar_clamp0", bus.bar_y_t, 0);
      repeat (3) frame(1'b0, 1'b1, 1'b0);
      check("bar_down3", bus.bar_y_t, 12);
      frame(1'b1, 1'b1, 1'b0);
      check("bar_both", bus.bar_y_t, 12);
      check("idle_state", bus.state, 0);
      check("idle_en", bus.ball_en, 0);

      // serve and bottom wall bounce
      do_reset();
      frame(1'b0, 1'b0, 1'b1);
      check("serve_state", bus.state, 1);
      check("serve_en", bus.ball_en, 1);
      check("serve_bx", bus.ball_x_l, 316);
      check("serve_by", bus.ball_y_t, 236);
      frame(1'b0, 1'b0, 1'b0);
      check("f1_bx", bus.ball_x_l, 318);
      check("f1_by", bus.ball_y_t, 238);
      repeat (116) frame(1'b0, 1'b0, 1'b0);
      frame(1'b0, 1'b0, 1'b0);
      check("f118_by", bus.ball_y_t, 472);
      check("f118_bx", bus.ball_x_l, 552);
      frame(1'b0, 1'b0, 1'b0);
      check("f119_by", bus.ball_y_t, 470);

      // paddle hit with paddle at bottom clamp
      do_reset();
      repeat (51) frame(1'b0, 1'b1, 1'b0);
      check("bar_408", bus.bar_y_t, 408);
      frame(1'b0, 1'b0, 1'b1);
      repeat (138) frame(1'b0, 1'b0, 1'b0);
      check("pre_hit_bx", bus.ball_x_l, 592);
      check("pre_hit_none", hit_tot, 0);
      frame(1'b0, 1'b0, 1'b0);
      check("hit_pulse", hit_n, 1);
      check("hit_bx", bus.ball_x_l, 592);
      check("hit_by", bus.ball_y_t, 430);
      check("hit_no_miss", miss_n, 0);
      frame(1'b0, 1'b0, 1'b0);
      check("post_hit_bx", bus.ball_x_l, 590);
      check("post_hit_by", bus.ball_y_t, 428);
      check("post_hit_pulse", hit_n, 0);

      // miss and hold-off back to IDLE, serve ignored meanwhile
      do_reset();
      frame(1'b0, 1'b0, 1'b1);
      repeat (158) frame(1'b0, 1'b0, 1'b0);
      check("pre_miss_state", bus.state, 1);
      frame(1'b0, 1'b0, 1'b0);
      check("miss_pulse", miss_n, 1);
      check("miss_state", bus.state, 2);
      check("miss_en", bus.ball_en, 0);
      check("miss_no_hit", hit_tot, 0);
      repeat (59) frame(1'b0, 1'b0, 1'b1);
      check("miss_hold_state", bus.state, 2);
      frame(1'b0, 1'b0, 1'b0);
      check("back_idle", bus.state, 0);
      check("back_bx", bus.ball_x_l, 316);
      check("back_by", bus.ball_y_t, 236);
      check("back_en", bus.ball_en, 0);
      check("miss_bar", bus.bar_y_t, 204);

      // reset coincident with a frame tick during play
      do_reset();
      frame(1'b0, 1'b0, 1'b1);
      repeat (10) frame(1'b0, 1'b1, 1'b0);
      check("play_bx", bus.ball_x_l, 336);
      @(negedge clk);
      bus.btn_down = 1'b0;
      bus.pixel_y  = 10'd481;
      bus.pixel_x  = 10'd0;
      rst = 1'b0;
      @(negedge clk);
      rst = 1'b1;
      bus.pixel_y = 10'd0;
      check("rst2_bar", bus.bar_y_t, 204);
      check("rst2_bx", bus.ball_x_l, 316);
      check("rst2_by", bus.ball_y_t, 236);
      check("rst2_state", bus.state, 0);
      check("rst2_en", bus.ball_en, 0);
      check("rst2_hit", bus.hit, 0);
      check("rst2_miss", bus.miss, 0);
      frame(1'b0, 1'b0, 1'b0);
      check("rst2_idle", bus.state, 0);

      $display("%0d/%0d checks passed", passed, checks);
      $finish;
   end

endmodule
